keccak_rc_gen: RTL



---
 rtl/keccak_rc_pkg.sv | 43 ++++
 rtl/keccak_rc_gen_if.sv | 27 ++
 rtl/keccak_rc_round_step.sv | 24 ++
 rtl/keccak_rc_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/keccak_rc_pkg.sv
// Shared constants, LFSR helpers and FSM state type for the Keccak iota
// round-constant generator.
package keccak_rc_pkg;

  localparam logic [7:0] LFSR_POLY = 8'h71;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2
  } rc_state_e;

  // One step of x^8+x^6+x^5+x^4+1; the feedback taps below bit 8 are 0x71.
  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? LFSR_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] lfsr_advance(input logic [7:0] r, input int n);
    logic [7:0] s;
    s = r;
    for (int i = 0; i < n; i++) begin
      s = lfsr_step(s);
    end
    return s;
  endfunction

  // Bit j of the round lands at lane position 2^j-1; positions at or beyond
  // the lane width are dropped, so callers truncate the result to W bits.
  function automatic logic [63:0] rc_expand(input logic [6:0] bits7, input int w);
    logic [63:0] lane;
    lane     = '0;
    lane[0]  = bits7[0];
    lane[1]  = bits7[1];
    lane[3]  = bits7[2];
    lane[7]  = bits7[3];
    if (w > 15) lane[15] = bits7[4];
    if (w > 31) lane[31] = bits7[5];
    if (w > 63) lane[63] = bits7[6];
    return lane;
  endfunction

endpackage

// File: rtl/keccak_rc_gen_if.sv
// Round-constant channel between the generator and the Keccak round datapath,
// plus the permutation start/busy/done controls.
interface keccak_rc_gen_if #(
  parameter int W = 32
);
  logic         start;
  logic         rc_ready;
  logic [W-1:0] rc;
  logic         rc_valid;
  logic [4:0]   rc_round;
  logic         rc_last;
  logic         busy;
  logic         done;

  // Handshake: a constant transfers on a rising edge with rc_valid && rc_ready.
  // Once rc_valid is high, rc/rc_round/rc_last hold until that edge; rc_ready
  // may be high at any time and is ignored while rc_valid is low.
  modport master (
    input  start, rc_ready,
    output rc, rc_valid, rc_round, rc_last, busy, done
  );

  modport slave (
    output start, rc_ready,
    input  rc, rc_valid, rc_round, rc_last, busy, done
  );
endinterface

// File: rtl/keccak_rc_round_step.sv
// Seven unrolled LFSR steps: emits one round's sequence bits (bit 0 first)
// and the LFSR state that starts the following round.
module keccak_rc_round_step
  import keccak_rc_pkg::*;
(
  input  logic [7:0] state_in,
  output logic [6:0] seq_bits,
  output logic [7:0] state_out
);

  logic [7:0] r;

  // Shift in from the top so that the first sampled bit ends at seq_bits[0].
  always_comb begin
    r        = state_in;
    seq_bits = '0;
    for (int j = 0; j < 7; j++) begin
      seq_bits = {r[0], seq_bits[6:1]};
      r        = lfsr_step(r);
    end
    state_out = r;
  end

endmodule

// File: rtl/keccak_rc_gen.sv
// Keccak iota round-constant generator: one W-bit constant per round over a
// valid/ready channel, either a full round per clock or one LFSR step per clock.
module keccak_rc_gen
  import keccak_rc_pkg::*;
#(
  parameter int W       = 32,
  parameter int NROUNDS = 12 + 2 * $clog2(W),
  parameter bit SERIAL  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  keccak_rc_gen_if.master rc_if,
  output rc_state_e       dbg_state
);

  localparam int         L           = $clog2(W);
  localparam int         MAX_ROUNDS  = 12 + 2 * L;
  localparam int         FIRST       = MAX_ROUNDS - NROUNDS;
  localparam logic [4:0] FIRST_ROUND = 5'(FIRST);
  localparam logic [4:0] LAST_ROUND  = 5'(MAX_ROUNDS - 1);
  // Reduced-round permutations start mid-sequence; fold the skipped steps in
  // at elaboration time.
  localparam logic [7:0] START_STATE = lfsr_advance(LFSR_SEED, 7 * FIRST);

  rc_state_e    state_q, state_d;
  logic [7:0]   lfsr_q, lfsr_d;
  logic [W-1:0] rc_q, rc_d;
  logic [4:0]   round_q, round_d;
  logic         last_q, last_d;
  logic         done_q, done_d;
  logic [2:0]   k_q, k_d;
  logic [6:0]   bits_q, bits_d;

  logic [7:0]   step_in;
  logic [6:0]   step_bits;
  logic [7:0]   step_state;
  logic         rc_valid;

  assign step_in  = (state_q == ST_IDLE) ? START_STATE : lfsr_q;
  assign rc_valid = (state_q == ST_HOLD);

  if (!SERIAL) begin : g_par
    keccak_rc_round_step u_step (
      .state_in  (step_in),
      .seq_bits  (step_bits),
      .state_out (step_state)
    );
  end else begin : g_ser
    assign step_bits  = '0;
    assign step_state = '0;
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    rc_d    = rc_q;
    round_d = round_q;
    last_d  = last_q;
    done_d  = 1'b0;
    k_d     = k_q;
    bits_d  = bits_q;

    case (state_q)
      ST_IDLE: begin
        if (rc_if.start) begin
          round_d = FIRST_ROUND;
          last_d  = (NROUNDS == 1);
          if (SERIAL) begin
            state_d = ST_GEN;
            lfsr_d  = START_STATE;
            rc_d    = '0;
            bits_d  = '0;
            k_d     = '0;
          end else begin
            state_d = ST_HOLD;
            lfsr_d  = step_state;
            rc_d    = W'(rc_expand(step_bits, W));
          end
        end
      end

      ST_GEN: begin
        // rc is rebuilt from the bits gathered so far, so it fills in as k advances.
        bits_d[k_q] = lfsr_q[0];
        rc_d        = W'(rc_expand(bits_d, W));
        lfsr_d      = lfsr_step(lfsr_q);
        k_d         = k_q + 3'd1;
        if (k_q == 3'd6) begin
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (rc_if.rc_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 5'd1;
            last_d  = ((round_q + 5'd1) == LAST_ROUND);
            if (SERIAL) begin
              state_d = ST_GEN;
              rc_d    = '0;
              bits_d  = '0;
              k_d     = '0;
            end else begin
              lfsr_d = step_state;
              rc_d   = W'(rc_expand(step_bits, W));
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      rc_q    <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      k_q     <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rc_q    <= rc_d;
      round_q <= round_d;
      last_q  <= last_d;
      done_q  <= done_d;
      k_q     <= k_d;
      bits_q  <= bits_d;
    end
  end

  assign rc_if.rc       = rc_q;
  assign rc_if.rc_valid = rc_valid;
  assign rc_if.rc_round = round_q;
  assign rc_if.rc_last  = last_q;
  assign rc_if.busy     = (state_q != ST_IDLE);
  assign rc_if.done     = done_q;
  assign dbg_state      = state_q;

  // A stalled constant must not move until the datapath takes it.
  a_hold_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (rc_valid && !rc_if.rc_ready) |=>
      (rc_valid && $stable(rc_q) && $stable(round_q) && $stable(last_q))
  );

  a_done_pulse: assert property (
    @(posedge clk) disable iff (!rst_n) done_q |=> !done_q
  );

  a_state_legal: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == ST_IDLE) || (state_q == ST_HOLD) || (SERIAL && state_q == ST_GEN)
  );

endmodule
